hazard_match_tracker: RTL and testbench

// - Producer side of the hazard-unit interface. Tracks register addresses and

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_stage_reg.sv | 24 ++
 rtl/hazard_match_tracker.sv | 115 +++++++++++
 tb/tb_hazard_match_tracker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, stage record and forwarding encodings for the hazard tracker
package hazard_pkg;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              use1;
    logic              use2;
    logic [ADDR_W-1:0] wa3;
    logic              regWrite;
    logic              memtoReg;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_e;

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one pipeline stage record with async reset and sync clear to bubble
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter type rec_t = stage_rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  rec_t d,
  output rec_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_match_tracker.sv
// rtl/hazard_match_tracker.sv - tracks E/M/W register usage and drives match flags to the hazard unit
module hazard_match_tracker #(
  parameter int ADDR_W   = hazard_pkg::ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNT_W    = hazard_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidD,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic              Use1D,
  input  logic              Use2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              CntClr,
  output logic              Match_1E_M,
  output logic              Match_1E_W,
  output logic              Match_2E_M,
  output logic              Match_2E_W,
  output logic              Match_12D_E,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic [CNT_W-1:0]  StallCnt
);

  // Same layout as hazard_pkg::stage_rec_t, rebuilt here so ADDR_W overrides carry through.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              use1;
    logic              use2;
    logic [ADDR_W-1:0] wa3;
    logic              regWrite;
    logic              memtoReg;
  } rec_t;

  rec_t decRec;
  rec_t recE;
  rec_t recM;
  rec_t recW;
  logic [CNT_W-1:0] stallCnt;
  logic unusedFields;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a == b) && !(ZERO_REG && (a == '0));
  endfunction

  assign decRec = '{valid:    ValidD,
                    ra1:      RA1D,
                    ra2:      RA2D,
                    use1:     Use1D,
                    use2:     Use2D,
                    wa3:      WA3D,
                    regWrite: RegWriteD & ValidD,
                    memtoReg: MemtoRegD & ValidD};

  // Any stall or flush from the hazard unit leaves a bubble in E; M and W never hold.
  hazard_stage_reg #(.rec_t(rec_t)) stageE (
    .clk  (clk),
    .reset(reset),
    .clear(StallD | FlushE),
    .d    (decRec),
    .q    (recE)
  );

  hazard_stage_reg #(.rec_t(rec_t)) stageM (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (recE),
    .q    (recM)
  );

  hazard_stage_reg #(.rec_t(rec_t)) stageW (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (recM),
    .q    (recW)
  );

  assign Match_1E_M  = recE.valid & recE.use1 & recM.valid & hit(recE.ra1, recM.wa3);
  assign Match_1E_W  = recE.valid & recE.use1 & recW.valid & hit(recE.ra1, recW.wa3);
  assign Match_2E_M  = recE.valid & recE.use2 & recM.valid & hit(recE.ra2, recM.wa3);
  assign Match_2E_W  = recE.valid & recE.use2 & recW.valid & hit(recE.ra2, recW.wa3);
  assign Match_12D_E = ValidD & recE.valid &
                       ((Use1D & hit(RA1D, recE.wa3)) | (Use2D & hit(RA2D, recE.wa3)));

  assign RegWriteM = recM.regWrite;
  assign RegWriteW = recW.regWrite;
  assign MemtoRegE = recE.memtoReg;

  assign unusedFields = ^{recM.ra1, recM.ra2, recM.use1, recM.use2, recM.memtoReg,
                          recW.ra1, recW.ra2, recW.use1, recW.use2, recW.memtoReg};

  // Clear wins over a simultaneous stall; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (CntClr) begin
      stallCnt <= '0;
    end else if (StallD && FlushE && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign StallCnt = stallCnt;

endmodule

// File: tb/tb_hazard_match_tracker.sv
// tb/tb_hazard_match_tracker.sv - directed self-checking bench for hazard_match_tracker
module tb_hazard_match_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        validD, use1D, use2D, regWriteD, memtoRegD;
  logic [4:0]  ra1D, ra2D, wa3D;
  logic        stallD, flushE, cntClr;

  logic        m1EM, m1EW, m2EM, m2EW, m12DE, rwM, rwW, mrE;
  logic        zm1EM, zm1EW, zm2EM, zm2EW, zm12DE, zrwM, zrwW, zmrE;
  logic [15:0] cnt;
  logic [3:0]  zCnt;
  logic [7:0]  flags, zFlags;

  int nCompared = 0;
  int nMismatched = 0;

  assign flags  = {m1EM, m1EW, m2EM, m2EW, m12DE, rwM, rwW, mrE};
  assign zFlags = {zm1EM, zm1EW, zm2EM, zm2EW, zm12DE, zrwM, zrwW, zmrE};

  always #5 clk = ~clk;

  hazard_match_tracker dut (
    .clk(clk), .reset(reset), .ValidD(validD), .RA1D(ra1D), .RA2D(ra2D),
    .Use1D(use1D), .Use2D(use2D), .WA3D(wa3D), .RegWriteD(regWriteD),
    .MemtoRegD(memtoRegD), .StallD(stallD), .FlushE(flushE), .CntClr(cntClr),
    .Match_1E_M(m1EM), .Match_1E_W(m1EW), .Match_2E_M(m2EM), .Match_2E_W(m2EW),
    .Match_12D_E(m12DE), .RegWriteM(rwM), .RegWriteW(rwW), .MemtoRegE(mrE),
    .StallCnt(cnt)
  );

  hazard_match_tracker #(.ZERO_REG(1'b1), .CNT_W(4)) dutZ (
    .clk(clk), .reset(reset), .ValidD(validD), .RA1D(ra1D), .RA2D(ra2D),
    .Use1D(use1D), .Use2D(use2D), .WA3D(wa3D), .RegWriteD(regWriteD),
    .MemtoRegD(memtoRegD), .StallD(stallD), .FlushE(flushE), .CntClr(cntClr),
    .Match_1E_M(zm1EM), .Match_1E_W(zm1EW), .Match_2E_M(zm2EM), .Match_2E_W(zm2EW),
    .Match_12D_E(zm12DE), .RegWriteM(zrwM), .RegWriteW(zrwW), .MemtoRegE(zmrE),
    .StallCnt(zCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2, input logic [4:0] w,
                      input logic rw, input logic mr);
    validD = v; ra1D = a1; ra2D = a2; use1D = u1; use2D = u2;
    wa3D = w; regWriteD = rw; memtoRegD = mr;
    #1;
  endtask

  task automatic drain();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; stallD = 0; flushE = 0; cntClr = 0;
    setD(1, 3, 0, 1, 0, 3, 1, 0);
    tick();
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL reset_flags: got %b want %b", flags, 8'b0); end
    nCompared++;
    if (cnt !== 16'd0) begin nMismatched++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    nCompared++;
    if (zCnt !== 4'd0) begin nMismatched++; $display("FAIL reset_zcnt: got %0d want 0", zCnt); end
    reset = 1'b0;
    #1;
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL release_flags: got %b want %b", flags, 8'b0); end
    tick();
    nCompared++;
    if (flags !== 8'b00001000) begin nMismatched++; $display("FAIL stream_e1: got %b want %b", flags, 8'b00001000); end
    tick();
    nCompared++;
    if (flags !== 8'b10001100) begin nMismatched++; $display("FAIL stream_e2: got %b want %b", flags, 8'b10001100); end
    tick();
    nCompared++;
    if (flags !== 8'b11001110) begin nMismatched++; $display("FAIL stream_e3: got %b want %b", flags, 8'b11001110); end
    reset = 1'b1;
    #1;
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL midreset_flags: got %b want %b", flags, 8'b0); end
    nCompared++;
    if (zFlags !== 8'b0) begin nMismatched++; $display("FAIL midreset_zflags: got %b want %b", zFlags, 8'b0); end
    tick();
    reset = 1'b0;
    #1;
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL rerelease_flags: got %b want %b", flags, 8'b0); end
    tick();
    nCompared++;
    if (flags !== 8'b00001000) begin nMismatched++; $display("FAIL rerelease_e1: got %b want %b", flags, 8'b00001000); end
    tick();
    nCompared++;
    if (flags !== 8'b10001100) begin nMismatched++; $display("FAIL rerelease_e2: got %b want %b", flags, 8'b10001100); end
  endtask

  task automatic test_ex_forward();
    drain();
    setD(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    setD(1, 3, 0, 1, 0, 9, 0, 0);
    nCompared++;
    if (flags !== 8'b00001000) begin nMismatched++; $display("FAIL ex_decode: got %b want %b", flags, 8'b00001000); end
    tick();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    nCompared++;
    if (flags !== 8'b10000100) begin nMismatched++; $display("FAIL ex_match: got %b want %b", flags, 8'b10000100); end
    tick();
    nCompared++;
    if (flags !== 8'b00000010) begin nMismatched++; $display("FAIL ex_after: got %b want %b", flags, 8'b00000010); end
  endtask

  task automatic test_wb_forward();
    drain();
    setD(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    setD(1, 1, 1, 1, 1, 2, 0, 0);
    tick();
    setD(1, 0, 7, 0, 1, 8, 0, 0);
    nCompared++;
    if (flags !== 8'b00000100) begin nMismatched++; $display("FAIL wb_decode: got %b want %b", flags, 8'b00000100); end
    tick();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    nCompared++;
    if (flags !== 8'b00010010) begin nMismatched++; $display("FAIL wb_match: got %b want %b", flags, 8'b00010010); end
  endtask

  task automatic test_load_use();
    drain();
    setD(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    setD(1, 5, 0, 1, 0, 6, 1, 0);
    nCompared++;
    if (flags !== 8'b00001001) begin nMismatched++; $display("FAIL lu_detect: got %b want %b", flags, 8'b00001001); end
    stallD = 1; flushE = 1;
    tick();
    nCompared++;
    if (flags !== 8'b00000100) begin nMismatched++; $display("FAIL lu_bubble: got %b want %b", flags, 8'b00000100); end
    nCompared++;
    if (cnt !== 16'd1) begin nMismatched++; $display("FAIL lu_cnt: got %0d want 1", cnt); end
    stallD = 0; flushE = 0;
    tick();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    nCompared++;
    if (flags !== 8'b01000010) begin nMismatched++; $display("FAIL lu_wbfwd: got %b want %b", flags, 8'b01000010); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expSeq [3];
    expSeq[0] = 8'b00000100; expSeq[1] = 8'b00000010; expSeq[2] = 8'b00000000;
    drain();
    setD(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    setD(1, 5, 0, 1, 0, 6, 1, 0);
    stallD = 1; flushE = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (flags !== expSeq[i]) begin nMismatched++; $display("FAIL b2b_stall%0d: got %b want %b", i, flags, expSeq[i]); end
    end
    nCompared++;
    if (cnt !== 16'd4) begin nMismatched++; $display("FAIL b2b_cnt: got %0d want 4", cnt); end
    stallD = 0; flushE = 0;
  endtask

  task automatic test_false_hazard();
    drain();
    setD(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    setD(1, 1, 5, 1, 0, 6, 0, 0);
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL fh_nouse2: got %b want %b", flags, 8'b0); end
    setD(1, 5'b10101, 0, 1, 0, 6, 0, 0);
    nCompared++;
    if (flags !== 8'b0) begin nMismatched++; $display("FAIL fh_vector_d: got %b want %b", flags, 8'b0); end
    setD(1, 5'b00101, 0, 1, 0, 6, 0, 0);
    nCompared++;
    if (flags !== 8'b00001000) begin nMismatched++; $display("FAIL fh_scalar_d: got %b want %b", flags, 8'b00001000); end
    setD(1, 5'b10101, 0, 1, 0, 6, 0, 0);
    tick();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    nCompared++;
    if (flags !== 8'b00000100) begin nMismatched++; $display("FAIL fh_vector_e: got %b want %b", flags, 8'b00000100); end
    drain();
    setD(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    setD(1, 0, 0, 1, 0, 4, 0, 0);
    nCompared++;
    if (flags !== 8'b00001000) begin nMismatched++; $display("FAIL zero_d_main: got %b want %b", flags, 8'b00001000); end
    nCompared++;
    if (zFlags !== 8'b0) begin nMismatched++; $display("FAIL zero_d_zreg: got %b want %b", zFlags, 8'b0); end
    tick();
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    nCompared++;
    if (flags !== 8'b10000100) begin nMismatched++; $display("FAIL zero_e_main: got %b want %b", flags, 8'b10000100); end
    nCompared++;
    if (zFlags !== 8'b00000100) begin nMismatched++; $display("FAIL zero_e_zreg: got %b want %b", zFlags, 8'b00000100); end
  endtask

  task automatic test_counter();
    drain();
    cntClr = 1;
    tick();
    cntClr = 0;
    nCompared++;
    if (cnt !== 16'd0) begin nMismatched++; $display("FAIL cnt_clr: got %0d want 0", cnt); end
    stallD = 1; flushE = 1;
    repeat (20) tick();
    nCompared++;
    if (zCnt !== 4'd15) begin nMismatched++; $display("FAIL cnt_sat: got %0d want 15", zCnt); end
    nCompared++;
    if (cnt !== 16'd20) begin nMismatched++; $display("FAIL cnt_wide: got %0d want 20", cnt); end
    cntClr = 1;
    tick();
    nCompared++;
    if (zCnt !== 4'd0) begin nMismatched++; $display("FAIL cnt_clr_prio: got %0d want 0", zCnt); end
    nCompared++;
    if (cnt !== 16'd0) begin nMismatched++; $display("FAIL cnt_clr_prio_wide: got %0d want 0", cnt); end
    cntClr = 0;
    tick();
    nCompared++;
    if (zCnt !== 4'd1) begin nMismatched++; $display("FAIL cnt_resume: got %0d want 1", zCnt); end
    stallD = 0; flushE = 0;
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_back_to_back();
    test_false_hazard();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
